// File: rtl/qmult_seq.sv
// Sequential (Q,N) fixed-point multiplier: MSB-first shift-add over the multiplier magnitude, N-1 cycles per product.
// Build option QMULT_ROUND_EN: round half up on the magnitude instead of truncating.
// state | meaning
// IDLE  | o_complete=1, result held, waiting for i_start
// BUSY  | one shift-add per edge, count runs N-2 down to 0
module qmult_seq #(
    parameter int Q = 8,
    parameter int N = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_multiplicand,
    input  logic [N-1:0] i_multiplier,
    input  logic         i_start,
    output logic [N-1:0] o_product,
    output logic         o_complete,
    output logic         o_overflow
);
    localparam int AW = 2*N - 2;
    localparam int CW = (N > 3) ? $clog2(N-1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_nxt;
    logic [N-2:0]    mag_a, mag_b;
    logic [N-2:0]    mag_in_a, mag_in_b;
    logic            sign_r;
    logic [AW-1:0]   acc, acc_step;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    product_r;
    logic            overflow_r;
    logic [N-2:0]    m;
    logic            ovf;
    logic            neg;
    logic [N-1:0]    result;
`ifdef QMULT_ROUND_EN
    logic            rnd_carry;
`endif

    always_comb begin
        mag_in_a = i_multiplicand[N-1] ? (~i_multiplicand[N-2:0] + 1'b1) : i_multiplicand[N-2:0];
        mag_in_b = i_multiplier[N-1]   ? (~i_multiplier[N-2:0] + 1'b1)   : i_multiplier[N-2:0];
    end

    always_comb begin
        acc_step = (acc << 1) + (mag_b[cnt] ? {{(N-1){1'b0}}, mag_a} : {AW{1'b0}});
`ifdef QMULT_ROUND_EN
        {rnd_carry, m} = {1'b0, acc_step[N-2+Q:Q]} + {{(N-1){1'b0}}, acc_step[Q-1]};
        ovf = (|acc_step[AW-1:N-1+Q]) | rnd_carry;
`else
        m   = acc_step[N-2+Q:Q];
        ovf = |acc_step[AW-1:N-1+Q];
`endif
        // a zero magnitude never carries a sign bit
        neg    = sign_r & (|m);
        result = {neg, neg ? (~m + 1'b1) : m};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = BUSY;
            BUSY:    if (cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            mag_a      <= '0;
            mag_b      <= '0;
            sign_r     <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            product_r  <= '0;
            overflow_r <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (i_start) begin
                    mag_a  <= mag_in_a;
                    mag_b  <= mag_in_b;
                    sign_r <= i_multiplicand[N-1] ^ i_multiplier[N-1];
                    acc    <= '0;
                    cnt    <= CW'(N-2);
                end
                BUSY: begin
                    acc <= acc_step;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        product_r  <= result;
                        overflow_r <= ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_product  = product_r;
    assign o_overflow = overflow_r;
    assign o_complete = (state == IDLE);

endmodule

// File: tb/tb_qmult_seq.sv
// Bench for qmult_seq: arithmetic reference model checked every cycle plus directed vectors with literal results.
module tb_qmult_seq;
    localparam int Q = 8;
    localparam int N = 16;
`ifdef QMULT_ROUND_EN
    localparam logic [N-1:0] RND_EXP = 16'h0001;
`else
    localparam logic [N-1:0] RND_EXP = 16'h0000;
`endif

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic [N-1:0] i_multiplicand = '0;
    logic [N-1:0] i_multiplier = '0;
    logic         i_start = 1'b0;
    logic [N-1:0] o_product;
    logic         o_complete;
    logic         o_overflow;

    int checks = 0;
    int passes = 0;
    bit cmp_en = 1'b0;

    qmult_seq #(.Q(Q), .N(N)) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_multiplicand(i_multiplicand),
        .i_multiplier(i_multiplier),
        .i_start(i_start),
        .o_product(o_product),
        .o_complete(o_complete),
        .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: integer magnitudes, integer product, then scale/wrap/sign by plain arithmetic.
    function automatic logic [N:0] model_fn(input logic [N-1:0] a, input logic [N-1:0] b);
        longint lim, ma, mb, p, s, m;
        logic neg, ov;
        logic [N-1:0] prod;
        lim = longint'(1) << (N-1);
        ma = a[N-1] ? (lim - longint'(a[N-2:0])) % lim : longint'(a[N-2:0]);
        mb = b[N-1] ? (lim - longint'(b[N-2:0])) % lim : longint'(b[N-2:0]);
        p  = ma * mb;
        s  = p >> Q;
`ifdef QMULT_ROUND_EN
        s  = s + ((p >> (Q-1)) & 1);
`endif
        ov   = (s >= lim);
        m    = s % lim;
        neg  = (a[N-1] ^ b[N-1]) && (m != 0);
        prod = neg ? N'((longint'(1) << N) - m) : N'(m);
        return {ov, prod};
    endfunction

    int           remaining = 0;
    logic [N-1:0] exp_prod  = '0;
    logic         exp_ov    = 1'b0;
    logic [N:0]   pend      = '0;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            remaining <= 0;
            exp_prod  <= '0;
            exp_ov    <= 1'b0;
        end else if (remaining == 0) begin
            if (i_start) begin
                pend      <= model_fn(i_multiplicand, i_multiplier);
                remaining <= N-1;
            end
        end else begin
            if (remaining == 1) begin
                exp_prod <= pend[N-1:0];
                exp_ov   <= pend[N];
            end
            remaining <= remaining - 1;
        end
    end

    always @(negedge i_clk) begin
        if (cmp_en) begin
            check("cyc_complete", 32'(o_complete), 32'(remaining == 0));
            check("cyc_product",  32'(o_product),  32'(exp_prod));
            check("cyc_overflow", 32'(o_overflow), 32'(exp_ov));
        end
    end

    task automatic wait_done(output int lat);
        lat = 0;
        while (o_complete == 1'b0 && lat < 40) begin
            lat++;
            @(negedge i_clk);
        end
    endtask

    task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] exp_p, input logic exp_o);
        int lat;
        @(negedge i_clk);
        i_multiplicand = a;
        i_multiplier   = b;
        i_start        = 1'b1;
        @(negedge i_clk);
        i_start        = 1'b0;
        i_multiplicand = N'($urandom);
        i_multiplier   = N'($urandom);
        wait_done(lat);
        check({name, "_latency"}, 32'(lat), 32'(N-1));
        check({name, "_product"}, 32'(o_product), 32'(exp_p));
        check({name, "_overflow"}, 32'(o_overflow), 32'(exp_o));
    endtask

    initial begin
        int lat;
        logic [N:0] r;

        r = model_fn(16'h0180, 16'h0200); check("model_pos", 32'(r), 32'h0_0300);
        r = model_fn(16'hFE80, 16'h0200); check("model_neg", 32'(r), 32'h0_FD00);
        r = model_fn(16'h4000, 16'h0400); check("model_ovf", 32'(r), 32'h1_0000);
        r = model_fn(16'hFE80, 16'h0000); check("model_nz",  32'(r), 32'h0_0000);

        repeat (2) @(negedge i_clk);
        check("rst_complete", 32'(o_complete), 32'd1);
        check("rst_product",  32'(o_product),  32'h0000);
        check("rst_overflow", 32'(o_overflow), 32'd0);
        cmp_en  = 1'b1;
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        check("idle_complete", 32'(o_complete), 32'd1);

        run_op("pos",      16'h0180, 16'h0200, 16'h0300, 1'b0);
        run_op("neg",      16'hFE80, 16'h0200, 16'hFD00, 1'b0);
        run_op("negzero",  16'hFE80, 16'h0000, 16'h0000, 1'b0);
        run_op("ovf",      16'h4000, 16'h0400, 16'h0000, 1'b1);
        run_op("negneg",   16'hFF00, 16'hFE00, 16'h0200, 1'b0);
        run_op("mostneg",  16'h8000, 16'h0200, 16'h0000, 1'b0);
        run_op("frac",     16'h0080, 16'h0080, 16'h0040, 1'b0);
        run_op("wrap",     16'h7FFF, 16'h7FFF, 16'h7F00, 1'b1);
        run_op("round",    16'h0001, 16'h0080, RND_EXP,  1'b0);

        // start pulse during BUSY must be ignored
        @(negedge i_clk);
        i_multiplicand = 16'h0180;
        i_multiplier   = 16'h0200;
        i_start        = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (4) @(negedge i_clk);
        i_multiplicand = 16'h0100;
        i_multiplier   = 16'h0100;
        i_start        = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done(lat);
        check("busy_latency", 32'(lat + 5), 32'(N-1));
        check("busy_product", 32'(o_product), 32'h0300);
        repeat (3) @(negedge i_clk);
        check("busy_no_rerun", 32'(o_complete), 32'd1);

        // reset mid-operation
        @(negedge i_clk);
        i_multiplicand = 16'h0180;
        i_multiplier   = 16'h0200;
        i_start        = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (6) @(negedge i_clk);
        check("pre_abort_busy", 32'(o_complete), 32'd0);
        #2 i_rst_n = 1'b0;
        #1;
        check("abort_complete", 32'(o_complete), 32'd1);
        check("abort_product",  32'(o_product),  32'h0000);
        check("abort_overflow", 32'(o_overflow), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        check("post_abort_idle", 32'(o_complete), 32'd1);

        run_op("recover", 16'h0300, 16'hFF00, 16'hFD00, 1'b0);
        repeat (2) @(negedge i_clk);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
